nn_address_generator: RTL and testbench
=======================================

# nn_address_generator

Address generator feeding the neuron datapath: steps through input-vector and weight memory addresses for every (neuron, input) pair of one fully-connected layer. It sits directly downstream of the control unit, consuming its `AG_rst`/`AG_read` strobes, and issues the per-neuron `forget` pulse back to the control unit. Memory reads are issued here; the accumulating ALU consumes the returned data qualified by `addr_valid`/`last`.

## Interface
- `N_INPUTS`, 4: inputs per neuron (≥1).
- `N_NEURONS`, 2: neurons in the layer (≥1).
- `ADDR_W`, 8: address width; must satisfy N_INPUTS·N_NEURONS ≤ 2^ADDR_W.
- `GAP`, 2: idle cycles inserted between neurons (memory latency / accumulator clear), ≥1.
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ag_rst` in 1: synchronous clear from control unit (active-high).
- `ag_read` in 1: prime/hold strobe from control unit (active-high).
- `in_addr` out ADDR_W: input-vector address = input index.
- `w_addr` out ADDR_W: weight address = neuron·N_INPUTS + input index.
- `addr_valid` out 1: addresses this cycle are a live beat.
- `last` out 1: beat is the final input of current neuron.
- `neuron_idx` out ADDR_W: current neuron.
- `forget` out 1: one-cycle pulse, neuron finished and more remain.
- `done` out 1: whole layer issued; sticky.

## Operation
- States: IDLE, PRIME, RUN, GAP, DONE. All outputs registered.
- Counters: `in_idx` (0..N_INPUTS-1), `neuron_idx` (0..N_NEURONS-1), `w_addr` as running counter (incremented with `in_idx`, no multiplier), `gap_cnt`.
- Priority per cycle: `reset_n`=0 > `ag_rst` > `ag_read` > normal stepping.
- `ag_rst`=1: all counters 0, state IDLE, all outputs 0. Overrides any state, including DONE and mid-neuron.
- `ag_read`=1 (ag_rst=0): IDLE/PRIME → PRIME; RUN → stall (no advance, addr_valid=0); GAP → GAP count continues; DONE → DONE. Addresses show current (neuron, in_idx).
- Both strobes 0:
  - IDLE → stays IDLE (prime required before first beat).
  - PRIME/RUN: emit beat (addr_valid=1); `last`=1 when in_idx=N_INPUTS-1. Non-last: in_idx++, w_addr++, → RUN. Last with neuron_idx<N_NEURONS-1: in_idx=0, neuron_idx++, w_addr++, forget=1 next cycle, → GAP. Last on final neuron: → DONE.
  - GAP: addr_valid=0, addresses present next neuron's first pair; after GAP cycles → RUN.
  - DONE: addr_valid=0, done=1 held until ag_rst or reset_n.
- `last` only ever asserted together with `addr_valid`.
- `forget` never asserted for final neuron; `done` replaces it.

## Timing
- Reset (reset_n low, async): state IDLE; in_addr, w_addr, neuron_idx=0; addr_valid, last, forget, done=0.
- Beat k's addresses valid in the cycle after the edge that sampled both strobes low; first beat appears 1 cycle after ag_read drops.
- Throughput 1 beat/cycle within a neuron; neuron-to-neuron: last beat, then GAP cycles of addr_valid=0, then first beat of next neuron.
- `forget` high exactly during the first GAP cycle.
- `done` rises the cycle after the final `last` beat.
- Total layer, no stalls: N_NEURONS·N_INPUTS + (N_NEURONS-1)·GAP cycles from first to done-1.
- N_INPUTS=1: every beat is `last`. N_NEURONS=1: no forget, no GAP.
- reset_n deasserted mid-operation is asynchronous; its release is synchronised externally.

## Test plan
- Reset: reset_n low with strobes random → all outputs 0 immediately; after release with ag_rst=0, ag_read=0, block stays IDLE, addr_valid=0.
- Full layer defaults: ag_rst 1 cycle, ag_read 2 cycles, then 0 → w_addr 0,1,2,3 (last on 3), forget pulse, 2 idle cycles, w_addr 4..7 (last on 7), done next cycle; in_addr 0..3 twice; done stays 1.
- Stall: ag_read=1 for 3 cycles after beat w_addr=1 → addr_valid=0 those cycles, resume at w_addr=2, no beat skipped or repeated.
- Mid-neuron clear: ag_rst=1 at w_addr=5 → next cycle all counters 0, IDLE, no forget/done.
- Boundary N_INPUTS=1, N_NEURONS=3, GAP=1 → beats w_addr 0,1,2 each with last; forget after beats 0 and 1 only; done after beat 2.
- Re-run after DONE: ag_rst then ag_read then 0 → identical sequence to second scenario.

Source files
------------

// File: rtl/nn_address_generator.sv
// nn_address_generator: steps input/weight addresses over every (neuron, input) pair of one layer.
module nn_address_generator #(
    parameter int N_INPUTS  = 4,
    parameter int N_NEURONS = 2,
    parameter int ADDR_W    = 8,
    parameter int GAP       = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ag_rst,
    input  logic              ag_read,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic              addr_valid,
    output logic              last,
    output logic [ADDR_W-1:0] neuron_idx,
    output logic              forget,
    output logic              done
);
    localparam int GW = $clog2(GAP + 1);
    typedef enum logic [2:0] {ST_IDLE, ST_PRIME, ST_RUN, ST_GAP, ST_DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] in_idx, n_cnt, w_cnt;
    logic [GW-1:0] gap_cnt;
    logic beat, is_last, is_final, gap_end;
    always_comb begin
        beat     = (state == ST_PRIME || state == ST_RUN) && !ag_read;
        is_last  = in_idx == ADDR_W'(N_INPUTS - 1);
        is_final = n_cnt == ADDR_W'(N_NEURONS - 1);
        gap_end  = gap_cnt == GW'(GAP - 1);
        state_nx = state;
        if (ag_rst) state_nx = ST_IDLE;
        else if (state == ST_IDLE) state_nx = ag_read ? ST_PRIME : ST_IDLE;
        else if (beat) state_nx = !is_last ? ST_RUN : is_final ? ST_DONE : ST_GAP;
        else if (state == ST_GAP && gap_end) state_nx = ST_RUN;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else state <= state_nx;
    end
    // Outputs show the pre-advance counters, so a beat carries the pair it issues.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {in_idx, n_cnt, w_cnt, gap_cnt} <= '0;
            {in_addr, w_addr, neuron_idx, addr_valid, last, forget, done} <= '0;
        end else if (ag_rst) begin
            {in_idx, n_cnt, w_cnt, gap_cnt} <= '0;
            {in_addr, w_addr, neuron_idx, addr_valid, last, forget, done} <= '0;
        end else begin
            addr_valid <= beat;
            last       <= beat && is_last;
            forget     <= state == ST_GAP && gap_cnt == '0;
            done       <= state == ST_DONE;
            in_addr    <= in_idx;
            w_addr     <= w_cnt;
            neuron_idx <= n_cnt;
            gap_cnt    <= state == ST_GAP ? gap_cnt + 1'b1 : '0;
            if (beat && !(is_last && is_final)) begin
                in_idx <= is_last ? '0 : in_idx + 1'b1;
                n_cnt  <= n_cnt + ADDR_W'(is_last);
                w_cnt  <= w_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nn_address_generator.sv
// tb_nn_address_generator: directed scenarios with a per-cycle expected-trace scoreboard.
module tb_nn_address_generator;
    logic clk = 1'b0;
    logic reset_n, ag_rst, ag_read;
    logic [7:0] ia, wa, na, ib, wb, nb;
    logic va, la, fa, da, vb, lb, fb, db;
    int checks = 0;
    int errors = 0;
    bit sel = 1'b0;

    typedef struct {logic v, l, f, d; int wx, ix, nx;} exp_t;
    exp_t q[$];

    nn_address_generator dut_a (
        .clk(clk), .reset_n(reset_n), .ag_rst(ag_rst), .ag_read(ag_read),
        .in_addr(ia), .w_addr(wa), .addr_valid(va), .last(la),
        .neuron_idx(na), .forget(fa), .done(da)
    );
    nn_address_generator #(.N_INPUTS(1), .N_NEURONS(3), .ADDR_W(8), .GAP(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .ag_rst(ag_rst), .ag_read(ag_read),
        .in_addr(ib), .w_addr(wb), .addr_valid(vb), .last(lb),
        .neuron_idx(nb), .forget(fb), .done(db)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] get_flags();
        return sel ? {28'd0, vb, lb, fb, db} : {28'd0, va, la, fa, da};
    endfunction
    function automatic logic [31:0] get_w();
        return sel ? {24'd0, wb} : {24'd0, wa};
    endfunction
    function automatic logic [31:0] get_i();
        return sel ? {24'd0, ib} : {24'd0, ia};
    endfunction
    function automatic logic [31:0] get_n();
        return sel ? {24'd0, nb} : {24'd0, na};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "/flags"}, get_flags(), 32'd0);
        chk({tag, "/w_addr"}, get_w(), 32'd0);
        chk({tag, "/in_addr"}, get_i(), 32'd0);
        chk({tag, "/neuron"}, get_n(), 32'd0);
    endtask

    // Expected cycle-by-cycle trace of a stall-free layer, starting with the first beat.
    task automatic push_layer(input int ni, input int nn, input int gp);
        for (int m = 0; m < nn; m++) begin
            for (int k = 0; k < ni; k++)
                q.push_back('{v: 1'b1, l: (k == ni - 1), f: 1'b0, d: 1'b0, wx: m * ni + k, ix: k, nx: m});
            if (m < nn - 1)
                for (int g = 0; g < gp; g++)
                    q.push_back('{v: 1'b0, l: 1'b0, f: (g == 0), d: 1'b0, wx: (m + 1) * ni, ix: 0, nx: m + 1});
        end
        q.push_back('{v: 1'b0, l: 1'b0, f: 1'b0, d: 1'b1, wx: -1, ix: 0, nx: 0});
    endtask

    task automatic drain(input int n, input string tag);
        exp_t e;
        for (int c = 0; c < n && q.size() > 0; c++) begin
            step();
            e = q.pop_front();
            chk({tag, "/flags"}, get_flags(), {28'd0, e.v, e.l, e.f, e.d});
            if (e.wx >= 0) begin
                chk({tag, "/w_addr"}, get_w(), e.wx);
                chk({tag, "/in_addr"}, get_i(), e.ix);
                chk({tag, "/neuron"}, get_n(), e.nx);
            end
        end
    endtask

    task automatic prime();
        ag_rst = 1'b1;
        step();
        ag_rst = 1'b0;
        ag_read = 1'b1;
        step();
        step();
        ag_read = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        ag_rst = 1'($urandom_range(0, 1));
        ag_read = 1'($urandom_range(0, 1));
        #2;
        check_idle("reset");
        @(negedge clk);
        ag_rst = 1'b0;
        ag_read = 1'b0;
        reset_n = 1'b1;
        repeat (3) begin
            step();
            check_idle("idle_after_reset");
        end

        ag_rst = 1'b1;
        step();
        check_idle("ag_rst");
        ag_rst = 1'b0;
        ag_read = 1'b1;
        step();
        step();
        check_idle("prime");
        ag_read = 1'b0;
        push_layer(4, 2, 2);
        drain(q.size(), "layer");
        repeat (3) begin
            step();
            chk("done_sticky", get_flags(), 32'd1);
        end

        prime();
        push_layer(4, 2, 2);
        drain(q.size(), "rerun");

        prime();
        push_layer(4, 2, 2);
        drain(2, "stall_pre");
        ag_read = 1'b1;
        repeat (3) begin
            step();
            chk("stall_flags", get_flags(), 32'd0);
            chk("stall_w_addr", get_w(), 32'd2);
        end
        ag_read = 1'b0;
        drain(q.size(), "stall_post");

        prime();
        push_layer(4, 2, 2);
        drain(8, "clear_pre");
        ag_rst = 1'b1;
        step();
        check_idle("clear");
        ag_rst = 1'b0;
        q.delete();
        repeat (3) begin
            step();
            check_idle("clear_idle");
        end

        prime();
        push_layer(4, 2, 2);
        drain(3, "async_pre");
        q.delete();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_idle("async_reset");
        #1;
        reset_n = 1'b1;
        step();
        check_idle("async_idle");

        sel = 1'b1;
        prime();
        push_layer(1, 3, 1);
        drain(q.size(), "narrow");
        step();
        chk("narrow_done_sticky", get_flags(), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
